// File: rtl/key_voice_allocator_if.sv
// Event bus from the PS/2 receiver into the voice allocator, plus the voice table
// and status the tone generators read back.
interface key_voice_allocator_if #(
  parameter int unsigned N_VOICES = 8
);
  localparam int unsigned CW = $clog2(N_VOICES + 1);

  logic [15:0]           keycode;
  logic                  start;
  logic [8*N_VOICES-1:0] notes;
  logic [CW-1:0]         note_num;
  logic [2:0]            zone_base;
  logic                  sustain;
  logic                  changed;
  logic                  stolen;

  modport master (
    output keycode, start,
    input  notes, note_num, zone_base, sustain, changed, stolen
  );

  modport slave (
    input  keycode, start,
    output notes, note_num, zone_base, sustain, changed, stolen
  );
endinterface

// File: rtl/key_voice_allocator.sv
// PS/2 make/break decoder with a fixed voice table: oldest-voice stealing,
// space-bar sustain and F1/F2 octave shift. Every output is registered.
module key_voice_allocator #(
  parameter int unsigned N_VOICES  = 8,
  parameter int unsigned BASE_ZONE = 4,
  parameter int unsigned MIN_ZONE  = 2,
  parameter int unsigned MAX_ZONE  = 6
) (
  input logic                  clk,
  input logic                  reset,
  key_voice_allocator_if.slave bus
);
  localparam int unsigned AW = $clog2(N_VOICES);
  localparam int unsigned CW = $clog2(N_VOICES + 1);
  localparam logic [AW-1:0] AgeMax = AW'(N_VOICES - 1);

  logic [N_VOICES-1:0] r_valid, w_valid_d;
  logic [N_VOICES-1:0] r_held, w_held_d;
  logic [4:0]          r_key [N_VOICES];
  logic [4:0]          w_key_d [N_VOICES];
  logic [7:0]          r_note [N_VOICES];
  logic [7:0]          w_note_d [N_VOICES];
  logic [AW-1:0]       r_age [N_VOICES];
  logic [AW-1:0]       w_age_d [N_VOICES];
  logic [2:0]          r_zone, w_zone_d;
  logic                r_sustain, w_sustain_d;
  logic [8*N_VOICES-1:0] r_notes, w_notes_d;
  logic [CW-1:0]       r_num, w_num_d;
  logic                r_changed, w_changed_d;
  logic                r_stolen, w_stolen_d;

  logic [5:0]    w_map;
  logic          w_map_hit, w_brk, w_ext, w_hit, w_free_found;
  logic [4:0]    w_idx;
  logic [3:0]    w_semi;
  logic [7:0]    w_new_note;
  logic [AW-1:0] w_hit_slot, w_free_slot, w_victim, w_victim_age, w_slot;

  // {mapped, key index}
  function automatic logic [5:0] f_decode(input logic [7:0] code);
    case (code)
      8'h1C: return {1'b1, 5'd0};
      8'h1D: return {1'b1, 5'd1};
      8'h1B: return {1'b1, 5'd2};
      8'h24: return {1'b1, 5'd3};
      8'h23: return {1'b1, 5'd4};
      8'h2B: return {1'b1, 5'd5};
      8'h2C: return {1'b1, 5'd6};
      8'h34: return {1'b1, 5'd7};
      8'h35: return {1'b1, 5'd8};
      8'h33: return {1'b1, 5'd9};
      8'h3C: return {1'b1, 5'd10};
      8'h3B: return {1'b1, 5'd11};
      8'h42: return {1'b1, 5'd12};
      8'h44: return {1'b1, 5'd13};
      8'h4B: return {1'b1, 5'd14};
      8'h4D: return {1'b1, 5'd15};
      8'h4C: return {1'b1, 5'd16};
      8'h52: return {1'b1, 5'd17};
      default: return 6'd0;
    endcase
  endfunction

  assign w_map      = f_decode(bus.keycode[7:0]);
  assign w_map_hit  = w_map[5];
  assign w_idx      = w_map[4:0];
  assign w_brk      = (bus.keycode[15:8] == 8'hF0);
  assign w_ext      = (bus.keycode[15:8] == 8'hE0);
  // Upper-row keys (index 12..17) wrap their low nibble onto semitones 1..6.
  assign w_semi     = (w_idx < 5'd12) ? (w_idx[3:0] + 4'd1) : (w_idx[3:0] - 4'd11);
  assign w_new_note = (w_idx < 5'd12) ? {1'b0, r_zone, w_semi} : {1'b0, r_zone + 3'd1, w_semi};

  always_comb begin
    w_hit        = 1'b0;
    w_hit_slot   = '0;
    w_free_found = 1'b0;
    w_free_slot  = '0;
    w_victim     = '0;
    w_victim_age = r_age[0];
    for (int i = 0; i < int'(N_VOICES); i++) begin
      if (r_valid[i] && (r_key[i] == w_idx) && !w_hit) begin
        w_hit      = 1'b1;
        w_hit_slot = AW'(i);
      end
      if (!r_valid[i] && !w_free_found) begin
        w_free_found = 1'b1;
        w_free_slot  = AW'(i);
      end
      if (r_age[i] > w_victim_age) begin
        w_victim     = AW'(i);
        w_victim_age = r_age[i];
      end
    end
  end

  always_comb begin
    w_valid_d   = r_valid;
    w_held_d    = r_held;
    w_key_d     = r_key;
    w_note_d    = r_note;
    w_age_d     = r_age;
    w_zone_d    = r_zone;
    w_sustain_d = r_sustain;
    w_stolen_d  = 1'b0;
    w_slot      = '0;
    w_notes_d   = '0;
    w_num_d     = '0;

    if (bus.start && !w_ext) begin
      if (bus.keycode[7:0] == 8'h29) begin
        w_sustain_d = !w_brk;
        if (w_brk) begin
          for (int i = 0; i < int'(N_VOICES); i++) begin
            if (r_valid[i] && !r_held[i]) w_valid_d[i] = 1'b0;
          end
        end
      end else if (bus.keycode[7:0] == 8'h05) begin
        if (!w_brk && (r_zone > 3'(MIN_ZONE))) w_zone_d = r_zone - 3'd1;
      end else if (bus.keycode[7:0] == 8'h06) begin
        if (!w_brk && (r_zone < 3'(MAX_ZONE))) w_zone_d = r_zone + 3'd1;
      end else if (w_map_hit) begin
        if (w_brk) begin
          if (w_hit) begin
            if (r_sustain) w_held_d[w_hit_slot] = 1'b0;
            else           w_valid_d[w_hit_slot] = 1'b0;
          end
        end else if (!(w_hit && r_held[w_hit_slot])) begin
          // Retrigger of a sustained voice, else allocate a free or stolen slot.
          w_slot     = w_hit ? w_hit_slot : (w_free_found ? w_free_slot : w_victim);
          w_stolen_d = !w_hit && !w_free_found;
          for (int i = 0; i < int'(N_VOICES); i++) begin
            if (r_valid[i] && (i != int'(w_slot)) && (r_age[i] != AgeMax)) begin
              w_age_d[i] = r_age[i] + AW'(1);
            end
          end
          w_valid_d[w_slot] = 1'b1;
          w_held_d[w_slot]  = 1'b1;
          w_age_d[w_slot]   = '0;
          if (!w_hit) begin
            w_key_d[w_slot]  = w_idx;
            w_note_d[w_slot] = w_new_note;
          end
        end
      end
    end

    for (int i = 0; i < int'(N_VOICES); i++) begin
      w_notes_d[8*i +: 8] = w_valid_d[i] ? w_note_d[i] : 8'h00;
      w_num_d             = w_num_d + CW'(w_valid_d[i]);
    end
    w_changed_d = (w_notes_d != r_notes);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid   <= '0;
      r_held    <= '0;
      for (int i = 0; i < int'(N_VOICES); i++) begin
        r_key[i]  <= '0;
        r_note[i] <= '0;
        r_age[i]  <= '0;
      end
      r_zone    <= 3'(BASE_ZONE);
      r_sustain <= 1'b0;
      r_notes   <= '0;
      r_num     <= '0;
      r_changed <= 1'b0;
      r_stolen  <= 1'b0;
    end else begin
      r_valid   <= w_valid_d;
      r_held    <= w_held_d;
      r_key     <= w_key_d;
      r_note    <= w_note_d;
      r_age     <= w_age_d;
      r_zone    <= w_zone_d;
      r_sustain <= w_sustain_d;
      r_notes   <= w_notes_d;
      r_num     <= w_num_d;
      r_changed <= w_changed_d;
      r_stolen  <= w_stolen_d;
    end
  end

  assign bus.notes     = r_notes;
  assign bus.note_num  = r_num;
  assign bus.zone_base = r_zone;
  assign bus.sustain   = r_sustain;
  assign bus.changed   = r_changed;
  assign bus.stolen    = r_stolen;
endmodule

// File: tb/tb_key_voice_allocator.sv
// Directed bench for a 4-voice allocator: each step queues its expected outputs,
// then pops and checks them one cycle after the event.
module tb_key_voice_allocator;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  typedef struct {
    string       tag;
    logic [31:0] notes;
    logic [2:0]  num;
    logic [2:0]  zone;
    logic        sus;
    logic        chg;
    logic        stl;
  } exp_t;

  exp_t sb[$];

  key_voice_allocator_if #(.N_VOICES(4)) bus ();

  key_voice_allocator #(
    .N_VOICES (4),
    .BASE_ZONE(4),
    .MIN_ZONE (2),
    .MAX_ZONE (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic st, input logic [15:0] kc,
                      input logic [31:0] en, input logic [2:0] num, input logic [2:0] zone,
                      input logic sus, input logic chg, input logic stl);
    exp_t e;
    exp_t got;
    @(negedge clk);
    reset       = rst;
    bus.start   = st;
    bus.keycode = kc;
    e = '{tag: tag, notes: en, num: num, zone: zone, sus: sus, chg: chg, stl: stl};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      got = sb.pop_front();
      chk({got.tag, ".notes"}, bus.notes, got.notes);
      chk({got.tag, ".num"}, 32'(bus.note_num), 32'(got.num));
      chk({got.tag, ".zone"}, 32'(bus.zone_base), 32'(got.zone));
      chk({got.tag, ".sus"}, 32'(bus.sustain), 32'(got.sus));
      chk({got.tag, ".chg"}, 32'(bus.changed), 32'(got.chg));
      chk({got.tag, ".stl"}, 32'(bus.stolen), 32'(got.stl));
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.keycode = 16'h0000;

    step("rst0",    1, 0, 16'h0000, 32'h0, 0, 4, 0, 0, 0);
    step("mk1C",    0, 1, 16'h001C, 32'h00000041, 1, 4, 0, 1, 0);
    step("brk1C",   0, 1, 16'hF01C, 32'h00000000, 0, 4, 0, 1, 0);
    step("idle",    0, 0, 16'h001C, 32'h00000000, 0, 4, 0, 0, 0);
    step("ext1C",   0, 1, 16'hE01C, 32'h00000000, 0, 4, 0, 0, 0);
    step("unmap",   0, 1, 16'h0015, 32'h00000000, 0, 4, 0, 0, 0);

    // Fill all four slots, then steal the oldest
    step("f1C",     0, 1, 16'h001C, 32'h00000041, 1, 4, 0, 1, 0);
    step("f1B",     0, 1, 16'h001B, 32'h00004341, 2, 4, 0, 1, 0);
    step("f23",     0, 1, 16'h0023, 32'h00454341, 3, 4, 0, 1, 0);
    step("f2B",     0, 1, 16'h002B, 32'h46454341, 4, 4, 0, 1, 0);
    step("steal34", 0, 1, 16'h0034, 32'h46454348, 4, 4, 0, 1, 1);
    step("postst",  0, 0, 16'h0000, 32'h46454348, 4, 4, 0, 0, 0);
    // Next oldest is slot1 (1B)
    step("steal35", 0, 1, 16'h0035, 32'h46454948, 4, 4, 0, 1, 1);
    step("rst1",    1, 0, 16'h0000, 32'h0, 0, 4, 0, 0, 0);

    step("rep1",    0, 1, 16'h001C, 32'h00000041, 1, 4, 0, 1, 0);
    step("rep2",    0, 1, 16'h001C, 32'h00000041, 1, 4, 0, 0, 0);
    step("rep3",    0, 1, 16'h001C, 32'h00000041, 1, 4, 0, 0, 0);
    step("rst2",    1, 0, 16'h0000, 32'h0, 0, 4, 0, 0, 0);

    step("sus_on",  0, 1, 16'h0029, 32'h00000000, 0, 4, 1, 0, 0);
    step("s_mk1C",  0, 1, 16'h001C, 32'h00000041, 1, 4, 1, 1, 0);
    step("s_br1C",  0, 1, 16'hF01C, 32'h00000041, 1, 4, 1, 0, 0);
    step("s_mk1D",  0, 1, 16'h001D, 32'h00004241, 2, 4, 1, 1, 0);
    step("sus_off", 0, 1, 16'hF029, 32'h00004200, 1, 4, 0, 1, 0);
    step("s_br1D",  0, 1, 16'hF01D, 32'h00000000, 0, 4, 0, 1, 0);
    // Retrigger of a sustained voice keeps it past pedal release
    step("r_sus",   0, 1, 16'h0029, 32'h00000000, 0, 4, 1, 0, 0);
    step("r_mk",    0, 1, 16'h001C, 32'h00000041, 1, 4, 1, 1, 0);
    step("r_br",    0, 1, 16'hF01C, 32'h00000041, 1, 4, 1, 0, 0);
    step("r_retrg", 0, 1, 16'h001C, 32'h00000041, 1, 4, 1, 0, 0);
    step("r_off",   0, 1, 16'hF029, 32'h00000041, 1, 4, 0, 0, 0);
    step("r_free",  0, 1, 16'hF01C, 32'h00000000, 0, 4, 0, 1, 0);
    step("rst3",    1, 0, 16'h0000, 32'h0, 0, 4, 0, 0, 0);

    step("f2_a",    0, 1, 16'h0006, 32'h00000000, 0, 5, 0, 0, 0);
    step("f2_b",    0, 1, 16'h0006, 32'h00000000, 0, 6, 0, 0, 0);
    step("f2_c",    0, 1, 16'h0006, 32'h00000000, 0, 6, 0, 0, 0);
    step("mk42",    0, 1, 16'h0042, 32'h00000071, 1, 6, 0, 1, 0);
    step("f1_a",    0, 1, 16'h0005, 32'h00000071, 1, 5, 0, 0, 0);
    step("mk1Cz5",  0, 1, 16'h001C, 32'h00005171, 2, 5, 0, 1, 0);
    step("brk42",   0, 1, 16'hF042, 32'h00005100, 1, 5, 0, 1, 0);
    step("f1_b",    0, 1, 16'h0005, 32'h00005100, 1, 4, 0, 0, 0);
    step("f1_c",    0, 1, 16'h0005, 32'h00005100, 1, 3, 0, 0, 0);
    step("f1_d",    0, 1, 16'h0005, 32'h00005100, 1, 2, 0, 0, 0);
    step("f1_e",    0, 1, 16'h0005, 32'h00005100, 1, 2, 0, 0, 0);
    step("brkF1",   0, 1, 16'hF005, 32'h00005100, 1, 2, 0, 0, 0);

    step("pre_rs",  0, 1, 16'h0029, 32'h00005100, 1, 2, 1, 0, 0);
    step("rs_st",   1, 1, 16'h001C, 32'h00000000, 0, 4, 0, 0, 0);
    step("post_rs", 0, 0, 16'h0000, 32'h00000000, 0, 4, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
